// File: rtl/i2c_master_core_if.sv
// i2c_master_core_if: host-side request/response signals of the single-byte I2C master.
interface i2c_master_core_if;
  logic start;
  logic rw;
  logic [6:0] address;
  logic [7:0] datasend;
  logic [7:0] datareceive;
  logic ready;
  logic sended;
  logic received;
  logic ack_error;
  modport master (output start, rw, address, datasend, input datareceive, ready, sended, received, ack_error);
  modport slave (input start, rw, address, datasend, output datareceive, ready, sended, received, ack_error);
endinterface

// File: rtl/i2c_master_core.sv
// i2c_master_core: single-byte I2C master (START, address, one data byte, STOP) with open-drain scl/sda.
// Each phase is four quarter ticks of QDIV clocks; a slave holding scl low in Q1 freezes the divider.
module i2c_master_core #(
  parameter int unsigned QDIV = 250
) (
  input logic clk,
  input logic reset,
  i2c_master_core_if.slave bus,
  inout wire scl,
  inout wire sda
);
  typedef enum logic [3:0] {IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MNACK, STOP} state_t;
  state_t state, state_n;
  logic [15:0] div;
  logic [1:0] q;
  logic [2:0] bitc;
  logic [7:0] tx, rx, data;
  logic rw, samp, scl_low, sda_low, bit_slot, hold, tick, slot_end, accept;
  assign bit_slot = state inside {ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MNACK};
  assign hold = bit_slot && q == 2'd1 && !scl;
  assign tick = state != IDLE && !hold && div == 16'(QDIV - 1);
  assign slot_end = tick && q == 2'd3;
  assign accept = state == IDLE && bus.start;
  assign bus.ready = state == IDLE;
  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;
  always_comb begin
    scl_low = bit_slot ? (q == 2'd0 || q == 2'd3) : state == START ? q[1] : state == STOP && q == 2'd0;
    sda_low = state inside {ADDR, WRITE} ? !tx[7] : state == START ? q != 2'd0 : state == STOP && !q[1];
  end
  always_comb begin
    state_n = state;
    if (accept) state_n = START;
    else if (slot_end)
      case (state)
        START: state_n = ADDR;
        ADDR: state_n = bitc == 3'd7 ? ADDR_ACK : ADDR;
        ADDR_ACK: state_n = samp ? STOP : rw ? READ : WRITE;
        WRITE: state_n = bitc == 3'd7 ? WRITE_ACK : WRITE;
        READ: state_n = bitc == 3'd7 ? MNACK : READ;
        WRITE_ACK, MNACK: state_n = STOP;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div <= '0;
      q <= '0;
      bitc <= '0;
      tx <= '0;
      rx <= '0;
      data <= '0;
      rw <= 1'b0;
      samp <= 1'b0;
      bus.datareceive <= '0;
      bus.sended <= 1'b0;
      bus.received <= 1'b0;
      bus.ack_error <= 1'b0;
    end else begin
      bus.sended <= 1'b0;
      bus.received <= 1'b0;
      div <= state == IDLE || tick ? '0 : hold ? div : div + 16'd1;
      if (tick) q <= q + 2'd1;
      if (accept) begin
        tx <= {bus.address, bus.rw};
        data <= bus.datasend;
        rw <= bus.rw;
        bus.ack_error <= 1'b0;
      end
      if (tick && q == 2'd2) begin
        samp <= sda;
        if (state == READ) rx <= {rx[6:0], sda};
      end
      if (slot_end) begin
        bitc <= bit_slot && state_n == state ? bitc + 3'd1 : 3'd0;
        if (state inside {ADDR, WRITE}) tx <= {tx[6:0], 1'b0};
        if (state == ADDR_ACK) tx <= data;
        if (state inside {ADDR_ACK, WRITE_ACK} && samp) bus.ack_error <= 1'b1;
        if (state == WRITE_ACK && !samp) bus.sended <= 1'b1;
        if (state == MNACK) begin
          bus.datareceive <= rx;
          bus.received <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: directed checks of the I2C master against a clocked slave/bus monitor (QDIV=4).
module tb_i2c_master_core;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stretch = 1'b0;
  logic s_sda_low = 1'b0;
  logic clr = 1'b0;
  wire scl, sda;
  int n_checks = 0, n_fail = 0, n;
  int n_start = 0, n_stop = 0, nbytes = 0, sended_cnt = 0, received_cnt = 0, both_cnt = 0;
  int bitn = 0, byte_idx = 0;
  logic [7:0] bus_bytes [4];
  logic ack_bits [4];
  logic [7:0] sh = 8'h00;
  logic [7:0] rd_byte = 8'h5A;
  logic pscl = 1'b1, psda = 1'b1, active = 1'b0, is_read = 1'b0;
  localparam logic [6:0] SLV = 7'h3C;
  i2c_master_core_if bus();
  i2c_master_core #(.QDIV(4)) dut (.clk(clk), .reset(reset), .bus(bus), .scl(scl), .sda(sda));
  pullup (scl);
  pullup (sda);
  assign scl = stretch ? 1'b0 : 1'bz;
  assign sda = s_sda_low ? 1'b0 : 1'bz;
  always #5 clk = ~clk;
  // Slave at 7'h3C plus bus monitor, sampling mid-cycle so DUT edges have settled
  always @(negedge clk) begin
    pscl <= scl;
    psda <= sda;
    if (bus.sended && bus.received) both_cnt <= both_cnt + 1;
    if (clr) begin
      n_start <= 0;
      n_stop <= 0;
      nbytes <= 0;
      sended_cnt <= 0;
      received_cnt <= 0;
    end else begin
      if (bus.sended) sended_cnt <= sended_cnt + 1;
      if (bus.received) received_cnt <= received_cnt + 1;
    end
    if (!reset) begin
      bitn <= 0;
      byte_idx <= 0;
      s_sda_low <= 1'b0;
      active <= 1'b0;
      is_read <= 1'b0;
    end else if (pscl && scl && psda && !sda) begin
      n_start <= n_start + 1;
      bitn <= 0;
      byte_idx <= 0;
      active <= 1'b1;
    end else if (pscl && scl && !psda && sda) begin
      n_stop <= n_stop + 1;
      active <= 1'b0;
    end else if (active && !pscl && scl) begin
      if (bitn < 8) sh <= {sh[6:0], sda};
      if (bitn == 7 && byte_idx < 4) begin
        bus_bytes[byte_idx] <= {sh[6:0], sda};
        nbytes <= byte_idx + 1;
      end
      if (bitn == 8 && byte_idx < 4) ack_bits[byte_idx] <= sda;
      bitn <= bitn + 1;
    end else if (active && pscl && !scl) begin
      if (bitn == 8 && byte_idx == 0) begin
        s_sda_low <= sh[7:1] == SLV;
        is_read <= sh[0] && sh[7:1] == SLV;
      end else if (bitn == 8) s_sda_low <= !is_read;
      else if (bitn == 9) begin
        bitn <= 0;
        byte_idx <= byte_idx + 1;
        s_sda_low <= is_read && byte_idx == 0 && !rd_byte[7];
      end else if (is_read && byte_idx == 1 && bitn > 0) s_sda_low <= !rd_byte[7 - bitn];
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic r, input logic [6:0] a, input logic [7:0] d, input logic keep);
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    bus.rw = r;
    bus.address = a;
    bus.datasend = d;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = keep;
    bus.rw = ~r;
    bus.address = ~a;
    bus.datasend = ~d;
  endtask
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!bus.ready && cnt < 2000) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.rw = 1'b0;
    bus.address = '0;
    bus.datasend = '0;
    #1;
    check("rst_ready", bus.ready, 1);
    check("rst_ack_error", bus.ack_error, 0);
    check("rst_sended", bus.sended, 0);
    check("rst_received", bus.received, 0);
    check("rst_datareceive", bus.datareceive, 8'h00);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    launch(1'b0, SLV, 8'hA5, 1'b0);
    check("wr_ready_drop", bus.ready, 0);
    wait_ready(n);
    check("wr_cycles", n, 320);
    check("wr_addr_byte", bus_bytes[0], 8'h78);
    check("wr_data_byte", bus_bytes[1], 8'hA5);
    check("wr_addr_ack", ack_bits[0], 0);
    check("wr_data_ack", ack_bits[1], 0);
    check("wr_nbytes", nbytes, 2);
    check("wr_sended", sended_cnt, 1);
    check("wr_received", received_cnt, 0);
    check("wr_ack_error", bus.ack_error, 0);
    check("wr_starts", n_start, 1);
    check("wr_stops", n_stop, 1);
    launch(1'b1, SLV, 8'h00, 1'b0);
    wait_ready(n);
    check("rd_cycles", n, 320);
    check("rd_addr_byte", bus_bytes[0], 8'h79);
    check("rd_data_byte", bus_bytes[1], 8'h5A);
    check("rd_master_nack", ack_bits[1], 1);
    check("rd_datareceive", bus.datareceive, 8'h5A);
    check("rd_received", received_cnt, 1);
    check("rd_sended", sended_cnt, 0);
    check("rd_stops", n_stop, 1);
    launch(1'b0, 7'h22, 8'hA5, 1'b0);
    wait_ready(n);
    check("nack_cycles", n, 176);
    check("nack_ack_error", bus.ack_error, 1);
    check("nack_addr_bit", ack_bits[0], 1);
    check("nack_nbytes", nbytes, 1);
    check("nack_sended", sended_cnt, 0);
    check("nack_stops", n_stop, 1);
    launch(1'b0, SLV, 8'hC3, 1'b0);
    check("clr_ack_error", bus.ack_error, 0);
    repeat (226) @(posedge clk);
    #1 stretch = 1'b1;
    repeat (52) @(posedge clk);
    #1 stretch = 1'b0;
    wait_ready(n);
    check("str_cycles", 278 + n, 370);
    check("str_data_byte", bus_bytes[1], 8'hC3);
    check("str_sended", sended_cnt, 1);
    check("str_stops", n_stop, 1);
    launch(1'b1, SLV, 8'h00, 1'b0);
    repeat (225) @(posedge clk);
    #1 check("abort_scl_before", scl, 0);
    reset = 1'b0;
    #1;
    check("abort_scl", scl, 1);
    check("abort_sda", sda, 1);
    check("abort_ready", bus.ready, 1);
    check("abort_datareceive", bus.datareceive, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("abort_received", received_cnt, 0);
    launch(1'b0, SLV, 8'h81, 1'b0);
    wait_ready(n);
    check("post_cycles", n, 320);
    check("post_addr_byte", bus_bytes[0], 8'h78);
    check("post_data_byte", bus_bytes[1], 8'h81);
    check("post_sended", sended_cnt, 1);
    launch(1'b0, SLV, 8'h66, 1'b1);
    bus.rw = 1'b0;
    bus.address = SLV;
    bus.datasend = 8'h66;
    wait_ready(n);
    check("held_cycles1", n, 320);
    @(posedge clk);
    #1 check("held_relaunch", bus.ready, 0);
    bus.start = 1'b0;
    wait_ready(n);
    check("held_cycles2", n, 320);
    check("held_sended", sended_cnt, 2);
    check("held_data_byte", bus_bytes[1], 8'h66);
    check("never_both_pulses", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_master_core.md
I2C_MASTER_CORE -- requirements
Module: i2c_master_core

Interface
REQ-001 SHALL have parameter QDIV, default 250, giving clk cycles per SCL quarter-period (tick); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, transaction request; sampled only while ready=1.
REQ-005 SHALL have port rw, input, 1, direction: 0 write one byte, 1 read one byte.
REQ-006 SHALL have port address, input, 7, target slave address.
REQ-007 SHALL have port datasend, input, 8, byte to write.
REQ-008 SHALL have port datareceive, output, 8, last byte read.
REQ-009 SHALL have port ready, output, 1, idle and able to accept start.
REQ-010 SHALL have port sended, output, 1, one-clk pulse: write byte ACKed.
REQ-011 SHALL have port received, output, 1, one-clk pulse: datareceive valid.
REQ-012 SHALL have port ack_error, output, 1, sticky: slave NACKed address or data.
REQ-013 SHALL have ports scl and sda, inout, 1 each, open-drain: driven 0 or released (Z), never driven 1.

Function
REQ-014 SHALL generate tick for one clk every QDIV clk cycles while not in IDLE; counter held at 0 in IDLE.
REQ-015 SHALL latch rw, address, datasend on the clk where start=1 and ready=1; ready drops next clk; later input changes ignored.
REQ-016 SHALL use states IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MNACK, STOP.
REQ-017 SHALL implement START as 4 ticks: Q0 both released, Q1 sda low (scl high), Q2 scl low, Q3 hold.
REQ-018 SHALL implement each bit slot as 4 ticks: Q0 scl low and sda set to bit, Q1 scl released, Q2 sda sampled (scl high), Q3 scl low.
REQ-019 SHALL hold Q1->Q2 advance while scl reads 0 after release (slave clock stretching); tick counter frozen meanwhile.
REQ-020 ADDR SHALL send {address, rw} MSB first, 8 slots; ADDR_ACK SHALL release sda and sample.
REQ-021 ADDR_ACK sample 0 -> WRITE if rw=0, READ if rw=1; sample 1 -> ack_error=1, STOP.
REQ-022 WRITE SHALL send datasend MSB first; WRITE_ACK sample 0 -> sended pulse at end of slot, STOP; sample 1 -> ack_error=1, STOP, no sended.
REQ-023 READ SHALL release sda for 8 slots, shifting sampled bits in MSB first.
REQ-024 MNACK SHALL release sda (master NACK) for one slot; at end datareceive loaded and received pulsed the same clk.
REQ-025 STOP SHALL be 4 ticks: Q0 sda low, scl low; Q1 scl released; Q2 sda released (scl high); Q3 hold; then IDLE, ready=1.
REQ-026 ack_error SHALL clear on next accepted start; sended and received never high together.
REQ-027 One byte per transaction; no repeated START; no arbitration (single-master bus).
REQ-028 Transaction length SHALL be exactly 4*(1+9+9+1)=80 ticks excluding stretch, identical for read and write.

Reset
REQ-029 On reset low, immediately (asynchronously): state IDLE, scl and sda released, ready=1, sended=0, received=0, ack_error=0, datareceive=8'h00, divider and bit counters 0.
REQ-030 Reset asserted mid-transaction SHALL abort with no STOP generated; bus released; no pulse emitted.
REQ-031 start held high continuously SHALL launch a new transaction one clk after each return to IDLE.

Verification
REQ-032 QDIV=4, write addr 7'h3C data 8'hA5, slave model ACKs -> SDA bytes 8'h78 then 8'hA5, one sended pulse, ack_error=0, ready after 320 clk plus start latency.
REQ-033 Read addr 7'h3C, slave returns 8'h5A -> address byte 8'h79, master NACK on ninth bit, datareceive=8'h5A with single received pulse.
REQ-034 Write to absent address (no ACK) -> ack_error=1, STOP follows address slot, no sended, no data byte on bus; next start clears ack_error.
REQ-035 Slave stretches SCL low 50 clk during data bit 3 -> bit timing resumes after release, byte still correct, total time +50 clk.
REQ-036 Reset pulsed during READ bit 4 -> scl/sda released same cycle, ready=1, no received, next transaction completes normally.
REQ-037 Checker asserts sda changes only while scl low, except START/STOP edges.
